sha256_config_sync: RTL and testbench

SHA256_CONFIG_SYNC -- requirements
Module: sha256_config_sync

---
 rtl/sha256_config_sync.sv | 140 ++++++++++++++
 tb/tb_sha256_config_sync.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_config_sync.sv
// sha256_config_sync: pairs an ID stream with a config stream in arrival order.
// Each input has a one-entry holding register. The joined pair is loaded into a
// registered output stage.
// A holding register may refill in the same cycle it is drained, so a steady
// stream moves one pair per cycle.
module sha256_config_sync (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en,
    input  logic        sync_rst,
    input  logic [5:0]  id_in,
    input  logic        id_in_last,
    input  logic        id_in_valid,
    output logic        id_in_ready,
    input  logic [63:0] cfg_in_size,
    input  logic [1:0]  cfg_in_scheme,
    input  logic        cfg_in_last,
    input  logic        cfg_in_valid,
    output logic        cfg_in_ready,
    output logic [63:0] cfg_out_size,
    output logic [1:0]  cfg_out_scheme,
    output logic [5:0]  cfg_out_id,
    output logic        cfg_out_last,
    output logic        cfg_out_valid,
    input  logic        cfg_out_ready
);

    // ID holding register (id_last is kept but never influences pairing)
    logic        id_full_q, id_full_d;
    logic [5:0]  id_data_q, id_data_d;
    logic        id_last_q, id_last_d;

    // Config holding register
    logic        cfg_full_q, cfg_full_d;
    logic [63:0] cfg_size_q, cfg_size_d;
    logic [1:0]  cfg_scheme_q, cfg_scheme_d;
    logic        cfg_last_q, cfg_last_d;

    // Output stage
    logic [63:0] out_size_q, out_size_d;
    logic [1:0]  out_scheme_q, out_scheme_d;
    logic [5:0]  out_id_q, out_id_d;
    logic        out_last_q, out_last_d;
    logic        out_valid_q, out_valid_d;

    logic        pair_join;
    logic        id_hs;
    logic        cfg_hs;

    // Join/ready decisions and next-state for holding registers and output stage
    always_comb begin
        pair_join    = id_full_q & cfg_full_q & (~out_valid_q | cfg_out_ready) & en;
        // Ready is forced low while nrst is held so nothing is accepted in reset
        id_in_ready  = nrst & en & (~id_full_q | pair_join);
        cfg_in_ready = nrst & en & (~cfg_full_q | pair_join);
        id_hs        = id_in_valid & id_in_ready;
        cfg_hs       = cfg_in_valid & cfg_in_ready;

        id_full_d    = id_full_q;
        id_data_d    = id_data_q;
        id_last_d    = id_last_q;
        cfg_full_d   = cfg_full_q;
        cfg_size_d   = cfg_size_q;
        cfg_scheme_d = cfg_scheme_q;
        cfg_last_d   = cfg_last_q;
        out_size_d   = out_size_q;
        out_scheme_d = out_scheme_q;
        out_id_d     = out_id_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q;

        // A handshake on the input takes priority, so a drained entry can refill at once
        if (id_hs) begin
            id_full_d = 1'b1;
            id_data_d = id_in;
            id_last_d = id_in_last;
        end else if (pair_join) begin
            id_full_d = 1'b0;
        end

        if (cfg_hs) begin
            cfg_full_d   = 1'b1;
            cfg_size_d   = cfg_in_size;
            cfg_scheme_d = cfg_in_scheme;
            cfg_last_d   = cfg_in_last;
        end else if (pair_join) begin
            cfg_full_d = 1'b0;
        end

        // A new pair replaces the beat leaving this cycle; otherwise a completed beat clears
        // valid. A beat can still leave while en is low.
        if (pair_join) begin
            out_size_d   = cfg_size_q;
            out_scheme_d = cfg_scheme_q;
            out_id_d     = id_data_q;
            out_last_d   = cfg_last_q;
            out_valid_d  = 1'b1;
        end else if (out_valid_q && cfg_out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; hard reset and soft clear both drop everything in flight
    always_ff @(posedge clk) begin
        if (!nrst || sync_rst) begin
            id_full_q    <= 1'b0;
            id_data_q    <= '0;
            id_last_q    <= 1'b0;
            cfg_full_q   <= 1'b0;
            cfg_size_q   <= '0;
            cfg_scheme_q <= '0;
            cfg_last_q   <= 1'b0;
            out_size_q   <= '0;
            out_scheme_q <= '0;
            out_id_q     <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            id_full_q    <= id_full_d;
            id_data_q    <= id_data_d;
            id_last_q    <= id_last_d;
            cfg_full_q   <= cfg_full_d;
            cfg_size_q   <= cfg_size_d;
            cfg_scheme_q <= cfg_scheme_d;
            cfg_last_q   <= cfg_last_d;
            out_size_q   <= out_size_d;
            out_scheme_q <= out_scheme_d;
            out_id_q     <= out_id_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign cfg_out_size   = out_size_q;
    assign cfg_out_scheme = out_scheme_q;
    assign cfg_out_id     = out_id_q;
    assign cfg_out_last   = out_last_q;
    assign cfg_out_valid  = out_valid_q;

endmodule

// File: tb/tb_sha256_config_sync.sv
// Testbench for sha256_config_sync. Accepted inputs are recorded as they happen.
// The Nth ID is paired with the Nth config, and the expected beat goes into a queue.
// Each output beat is compared against the front of that queue.
module tb_sha256_config_sync;

    logic        clk = 1'b0;
    logic        nrst, en, sync_rst;
    logic [5:0]  id_in;
    logic        id_in_last, id_in_valid, id_in_ready;
    logic [63:0] cfg_in_size;
    logic [1:0]  cfg_in_scheme;
    logic        cfg_in_last, cfg_in_valid, cfg_in_ready;
    logic [63:0] cfg_out_size;
    logic [1:0]  cfg_out_scheme;
    logic [5:0]  cfg_out_id;
    logic        cfg_out_last, cfg_out_valid, cfg_out_ready;

    int checks = 0;
    int failures = 0;
    int out_count = 0;
    int cyc = 0;
    bit rnd_done = 0;

    logic [5:0]  id_q[$];
    logic [66:0] cfg_q[$];
    logic [72:0] exp_q[$];
    int          out_cycles[$];
    bit          stall_pending = 0;
    logic [72:0] stall_data;

    always #5 clk = ~clk;

    sha256_config_sync dut (
        .clk(clk), .nrst(nrst), .en(en), .sync_rst(sync_rst),
        .id_in(id_in), .id_in_last(id_in_last), .id_in_valid(id_in_valid),
        .id_in_ready(id_in_ready),
        .cfg_in_size(cfg_in_size), .cfg_in_scheme(cfg_in_scheme),
        .cfg_in_last(cfg_in_last), .cfg_in_valid(cfg_in_valid),
        .cfg_in_ready(cfg_in_ready),
        .cfg_out_size(cfg_out_size), .cfg_out_scheme(cfg_out_scheme),
        .cfg_out_id(cfg_out_id), .cfg_out_last(cfg_out_last),
        .cfg_out_valid(cfg_out_valid), .cfg_out_ready(cfg_out_ready)
    );

    task automatic check(input string tag, input logic [72:0] obs, input logic [72:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Monitor: score output beats, check hold-while-stalled, record input accepts
    always @(negedge clk) begin
        logic [72:0] obs;
        logic [66:0] c;
        logic [5:0]  i;
        cyc++;
        obs = {cfg_out_size, cfg_out_scheme, cfg_out_id, cfg_out_last};
        if (stall_pending)
            check("out_hold", {cfg_out_valid, obs}, {1'b1, stall_data});
        stall_pending = cfg_out_valid && !cfg_out_ready;
        stall_data    = obs;
        if (nrst && !sync_rst) begin
            if (cfg_out_valid && cfg_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    check("beat", obs, exp_q.pop_front());
                end
                $display("beat %0d: size=%h scheme=%0d id=%0d last=%0d", out_count,
                         cfg_out_size, cfg_out_scheme, cfg_out_id, cfg_out_last);
                out_count++;
                out_cycles.push_back(cyc);
            end
            if (id_in_valid && id_in_ready) id_q.push_back(id_in);
            if (cfg_in_valid && cfg_in_ready)
                cfg_q.push_back({cfg_in_size, cfg_in_scheme, cfg_in_last});
            while (id_q.size() > 0 && cfg_q.size() > 0) begin
                c = cfg_q.pop_front();
                i = id_q.pop_front();
                exp_q.push_back({c[66:3], c[2:1], i, c[0]});
            end
        end
    end

    // Reset discards everything in flight, so the model forgets it too
    always @(posedge clk) begin
        if (!nrst || sync_rst) begin
            id_q.delete();
            cfg_q.delete();
            exp_q.delete();
            stall_pending = 0;
        end
    end

    task automatic send_id(input logic [5:0] id, input int gap);
        int t = 0;
        repeat (gap) begin @(posedge clk); #1; end
        id_in = id; id_in_last = id[0]; id_in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (id_in_ready) break;
            t++;
            if (t > 300) begin check("id_timeout", 1, 0); break; end
        end
        @(posedge clk); #1;
        id_in_valid = 1'b0;
    endtask

    task automatic send_cfg(input logic [63:0] size, input logic [1:0] scheme,
                            input logic last, input int gap);
        int t = 0;
        repeat (gap) begin @(posedge clk); #1; end
        cfg_in_size = size; cfg_in_scheme = scheme; cfg_in_last = last; cfg_in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (cfg_in_ready) break;
            t++;
            if (t > 300) begin check("cfg_timeout", 1, 0); break; end
        end
        @(posedge clk); #1;
        cfg_in_valid = 1'b0;
    endtask

    task automatic wait_outputs(input int target);
        int t = 0;
        while (out_count < target && t < 5000) begin @(posedge clk); t++; end
        #1;
        check("out_count", out_count, target);
    endtask

    initial begin
        int base;
        nrst = 1'b0; en = 1'b1; sync_rst = 1'b0; cfg_out_ready = 1'b0;
        id_in = '0; id_in_last = 1'b0; id_in_valid = 1'b0;
        cfg_in_size = '0; cfg_in_scheme = '0; cfg_in_last = 1'b0; cfg_in_valid = 1'b0;

        // Reset state: readies low while nrst low, outputs cleared
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_id_ready", id_in_ready, 0);
        check("rst_cfg_ready", cfg_in_ready, 0);
        check("rst_outputs", {cfg_out_size, cfg_out_scheme, cfg_out_id, cfg_out_last, cfg_out_valid}, 0);
        @(posedge clk); #1 nrst = 1'b1;
        @(negedge clk);
        check("post_rst_id_ready", id_in_ready, 1);
        check("post_rst_cfg_ready", cfg_in_ready, 1);
        @(posedge clk); #1;

        // Back-to-back stream, one beat per cycle
        cfg_out_ready = 1'b1;
        out_cycles.delete();
        base = out_count;
        fork
            begin send_id(0, 0); send_id(1, 0); send_id(2, 0); end
            begin
                send_cfg(64'h200, 2'd0, 1'b1, 0);
                send_cfg(64'h40, 2'd1, 1'b1, 0);
                send_cfg(64'h1F8, 2'd2, 1'b0, 0);
            end
        join
        wait_outputs(base + 3);
        check("b2b_rate", out_cycles[out_cycles.size()-1] - out_cycles[out_cycles.size()-3], 2);

        // Skewed arrival: config waits, its channel blocks, ID 7 arrives later
        repeat (2) @(posedge clk); #1;
        base = out_count;
        send_cfg(64'hABCD, 2'd3, 1'b1, 0);
        repeat (4) begin
            @(negedge clk);
            check("skew_cfg_ready", cfg_in_ready, 0);
            check("skew_id_ready", id_in_ready, 1);
        end
        @(posedge clk); #1;
        send_id(7, 0);
        check("skew_valid_early", cfg_out_valid, 0);
        @(posedge clk); #1;
        check("skew_valid", cfg_out_valid, 1);
        check("skew_id", cfg_out_id, 7);
        wait_outputs(base + 1);

        // Backpressure: output stalls, both holding registers fill
        cfg_out_ready = 1'b0;
        base = out_count;
        fork
            begin send_id(10, 0); send_id(11, 0); end
            begin send_cfg(64'h111, 2'd1, 1'b0, 0); send_cfg(64'h222, 2'd2, 1'b1, 0); end
        join
        repeat (4) begin
            @(negedge clk);
            check("bp_id_ready", id_in_ready, 0);
            check("bp_cfg_ready", cfg_in_ready, 0);
            check("bp_valid", cfg_out_valid, 1);
        end
        @(posedge clk); #1 cfg_out_ready = 1'b1;
        wait_outputs(base + 2);

        // Enable low mid-stream: readies low, no new beat, stream resumes in order
        base = out_count;
        fork
            begin for (int k = 0; k < 6; k++) send_id(6'(20 + k), 0); end
            begin for (int k = 0; k < 6; k++) send_cfg(64'(k * 64), 2'(k), 1'(k), 0); end
            begin
                repeat (3) @(posedge clk);
                #1 en = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("en_id_ready", id_in_ready, 0);
                    check("en_cfg_ready", cfg_in_ready, 0);
                    if (k > 0) check("en_no_join", cfg_out_valid, 0);
                end
                @(posedge clk); #1 en = 1'b1;
            end
        join
        wait_outputs(base + 6);

        // Soft clear with everything full, applied while en is low
        cfg_out_ready = 1'b0;
        fork
            begin send_id(40, 0); send_id(41, 0); end
            begin send_cfg(64'h333, 2'd3, 1'b1, 0); send_cfg(64'h444, 2'd0, 1'b0, 0); end
        join
        en = 1'b0; sync_rst = 1'b1;
        @(posedge clk); #1 sync_rst = 1'b0;
        check("srst_outputs", {cfg_out_size, cfg_out_scheme, cfg_out_id, cfg_out_last, cfg_out_valid}, 0);
        en = 1'b1;
        @(negedge clk);
        check("srst_id_ready", id_in_ready, 1);
        check("srst_cfg_ready", cfg_in_ready, 1);
        @(posedge clk); #1;

        // Hard reset with a lone ID pending: it must not pair afterwards
        send_id(50, 0);
        nrst = 1'b0;
        @(posedge clk); #1 nrst = 1'b1;
        cfg_out_ready = 1'b1;
        base = out_count;
        fork
            send_id(51, 0);
            send_cfg(64'h555, 2'd1, 1'b1, 2);
        join
        wait_outputs(base + 1);

        // Random gaps and output stalls
        base = out_count;
        fork
            begin for (int k = 0; k < 120; k++) send_id(6'($urandom), $urandom_range(0, 5)); end
            begin
                for (int k = 0; k < 120; k++)
                    send_cfg({$urandom, $urandom}, 2'($urandom), 1'($urandom), $urandom_range(0, 5));
            end
            begin
                while (!rnd_done) begin
                    cfg_out_ready = 1'b0;
                    repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
                    cfg_out_ready = 1'b1;
                    repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
                end
            end
            begin wait_outputs(base + 120); rnd_done = 1; end
        join
        cfg_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
